vpu_src_stream_port: RTL and testbench
======================================

// Module: vpu_src_stream_port
// PURPOSE
//  Parametrised multi-channel operand fetch port between the VPU controller and the SRAM read ports.
//  - Per channel: a strided burst of SRAM word reads from one command.
//  - Credit-based issue, so the operand queue never overflows.
//  - Each SRAM word is narrowed into VLANE-wide operand slices for the lanes.
//  - Generalises the fixed-port src port: channel count, burst length, stride and outstanding depth are all parameters.
// PARAMETERS
//  CH_CNT      2    number of independent read channels
//  AW          16   SRAM word address width
//  LW          8    burst length field width (max 2^LW-1 words)
//  IDW         4    SRAM read ID width
//  DW          512  SRAM data width
//  OW          256  operand slice width (OPERAND_WIDTH*VLANE_CNT); DW % OW == 0
//  DEPTH       8    operand queue depth in SRAM words (power of 2, >=2)
// PORTS
//  clk            in   1          clock
//  rst_n          in   1          asynchronous active-low reset
//  cmd_valid_i    in   1          command valid
//  cmd_ready_o    out  1          command ready (block idle)
//  cmd_ch_mask_i  in   CH_CNT     channels enabled by this command
//  cmd_base_i     in   CH_CNT*AW  per-channel start address
//  cmd_stride_i   in   CH_CNT*AW  per-channel address increment
//  cmd_len_i      in   CH_CNT*LW  per-channel word count
//  busy_o         out  1          command in progress
//  done_o         out  1          1-cycle pulse: all enabled channels received all data
//  err_o          out  1          sticky: rvalid with no outstanding request
//  sram_req_o     out  CH_CNT     read request
//  sram_ack_i     in   CH_CNT     request accepted
//  sram_addr_o    out  CH_CNT*AW  read address
//  sram_rid_o     out  CH_CNT*IDW read ID
//  sram_rlast_o   out  CH_CNT     last request of burst
//  sram_rvalid_i  in   CH_CNT     read data valid
//  sram_rdata_i   in   CH_CNT*DW  read data
//  opnd_rden_i    in   CH_CNT     pop one operand slice
//  opnd_rdata_o   out  CH_CNT*OW  current operand slice
//  opnd_empty_o   out  CH_CNT     no slice available
// BEHAVIOUR
//  Reset: cmd_ready_o=1; done_o, busy_o, err_o, sram_req_o, sram_rlast_o = 0; addr/rid = 0; queues empty (opnd_empty_o=1).
//  Command: accepted on cmd_valid_i & cmd_ready_o.
//   - Registers base, stride, len and mask for every channel.
//   - cmd_ready_o drops and busy_o rises the next cycle.
//  Per-channel FSM:
//   - IDLE -> ISSUE on accept if mask bit = 1 and len != 0; otherwise the channel is done at once.
//   - ISSUE -> DRAIN after the ack of request index len-1.
//   - DRAIN -> IDLE when outstanding reaches 0.
//  Issue rule: sram_req_o = 1 in ISSUE only while outstanding + queue_words < DEPTH.
//   - Once raised, req, addr, rid and rlast hold until sram_ack_i.
//   - ack with req=0 is ignored.
//  Request fields, request i:
//   - addr = base + i*stride, mod 2^AW, wrapping silently.
//   - rid = i mod 2^IDW.
//   - rlast = (i == len-1).
//  Responses: in order, one word per rvalid; the word is written to the queue the same cycle.
//   - outstanding is incremented on ack and decremented on rvalid; both in one cycle leave it unchanged.
//   - rvalid with outstanding == 0: data dropped, err_o set to 1 until reset.
//  done_o: pulses 1 cycle after the last enabled channel leaves DRAIN.
//   - If no channel has work, done_o pulses the cycle after accept.
//   - busy_o falls and cmd_ready_o rises in the same cycle as the done_o pulse.
//   - Queues need not be drained before the next command.
//  Read side: each queue word yields DW/OW slices, slice 0 = bits [OW-1:0] first.
//   - opnd_rdata_o is combinational from the head word and the slice counter.
//   - rden on the last slice pops the word.
//   - rden while empty is ignored: no state change, rdata holds.
//   - A write and a pop in the same cycle are allowed when the queue is full; occupancy is unchanged.
//  Reset mid-burst: all FSMs return to IDLE, the queues flush, and in-flight SRAM data after reset is ignored (no err_o).
// CONFIGURATION
//  VPU_SRC_STREAM_PERF_EN defined: adds output perf_stall_cnt_o [CH_CNT*32].
//   - Per channel, it counts cycles in ISSUE with req=0 because of the credit limit.
//   - It is cleared on command accept and saturates at 2^32-1.
//  VPU_SRC_STREAM_PERF_EN undefined: the port and counters are absent; other behaviour is identical.
// TESTING
//  1. CH0 base=0x10, stride=2, len=4, ack every cycle -> addrs 0x10,0x12,0x14,0x16; rid 0..3; rlast on 0x16 only; done_o 1 pulse.
//  2. DEPTH=8, len=12, no opnd_rden -> exactly 8 acks, then req stays 0; popping all slices of 1 word lets a 9th request issue.
//  3. mask=2'b01 with cmd_len ch1=5; separately len=0 on all channels -> ch1 never requests; done_o the cycle after accept.
//  4. DW/OW=2, word 0xA..B (hi A, lo B) -> first rden yields B, second yields A and pops; rden when empty leaves rdata unchanged.
//  5. base=0xFFFE, stride=1, len=3, AW=16 -> addrs 0xFFFE, 0xFFFF, 0x0000.
//  6. rvalid with 0 outstanding -> err_o = 1, queue unchanged; assert rst_n mid-burst -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/vpu_src_stream_port_if.sv
// Bus bundle for vpu_src_stream_port: command, SRAM read channels, operand read side.
// The slave modport is the port itself; master is the controller/SRAM environment.
interface vpu_src_stream_port_if #(
    parameter int CH_CNT = 2,
    parameter int AW     = 16,
    parameter int LW     = 8,
    parameter int IDW    = 4,
    parameter int DW     = 512,
    parameter int OW     = 256
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic [CH_CNT-1:0]     cmd_ch_mask_i;
    logic [CH_CNT*AW-1:0]  cmd_base_i;
    logic [CH_CNT*AW-1:0]  cmd_stride_i;
    logic [CH_CNT*LW-1:0]  cmd_len_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  err_o;
    logic [CH_CNT-1:0]     sram_req_o;
    logic [CH_CNT-1:0]     sram_ack_i;
    logic [CH_CNT*AW-1:0]  sram_addr_o;
    logic [CH_CNT*IDW-1:0] sram_rid_o;
    logic [CH_CNT-1:0]     sram_rlast_o;
    logic [CH_CNT-1:0]     sram_rvalid_i;
    logic [CH_CNT*DW-1:0]  sram_rdata_i;
    logic [CH_CNT-1:0]     opnd_rden_i;
    logic [CH_CNT*OW-1:0]  opnd_rdata_o;
    logic [CH_CNT-1:0]     opnd_empty_o;
    logic [CH_CNT*2-1:0]   dbg_state;

    modport slave (
        input  cmd_valid_i, cmd_ch_mask_i, cmd_base_i, cmd_stride_i, cmd_len_i,
        input  sram_ack_i, sram_rvalid_i, sram_rdata_i, opnd_rden_i,
        output cmd_ready_o, busy_o, done_o, err_o,
        output sram_req_o, sram_addr_o, sram_rid_o, sram_rlast_o,
        output opnd_rdata_o, opnd_empty_o, dbg_state
    );

    modport master (
        output cmd_valid_i, cmd_ch_mask_i, cmd_base_i, cmd_stride_i, cmd_len_i,
        output sram_ack_i, sram_rvalid_i, sram_rdata_i, opnd_rden_i,
        input  cmd_ready_o, busy_o, done_o, err_o,
        input  sram_req_o, sram_addr_o, sram_rid_o, sram_rlast_o,
        input  opnd_rdata_o, opnd_empty_o, dbg_state
    );
endinterface

// File: rtl/vpu_src_stream_port.sv
// Multi-channel strided SRAM operand fetch with credit-limited issue and per-channel operand queues.
// Optional VPU_SRC_STREAM_PERF_EN adds per-channel credit-stall counters (perf_stall_cnt_o).
module vpu_src_stream_port #(
    parameter int CH_CNT = 2,
    parameter int AW     = 16,
    parameter int LW     = 8,
    parameter int IDW    = 4,
    parameter int DW     = 512,
    parameter int OW     = 256,
    parameter int DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vpu_src_stream_port_if.slave  bus
`ifdef VPU_SRC_STREAM_PERF_EN
    ,
    output logic [CH_CNT*32-1:0]  perf_stall_cnt_o
`endif
);
    localparam int NS = DW / OW;
    localparam int SW = (NS > 1) ? $clog2(NS) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_DRAIN = 2'd2} ch_state_e;

    // Handshakes: cmd moves on cmd_valid_i & cmd_ready_o; an SRAM request moves on
    // sram_req_o & sram_ack_i and its fields stay stable until then; one word per rvalid.
    logic              busy_q, done_q, err_q;
    logic              accept;
    logic [CH_CNT-1:0] ch_idle_next;
    logic [CH_CNT-1:0] err_set;

    assign accept          = bus.cmd_valid_i & ~busy_q;
    assign bus.cmd_ready_o = ~busy_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;

    // done fires on the edge where every channel settles in IDLE, so busy drops with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= (busy_q | accept) & ~(&ch_idle_next);
            done_q <= (busy_q | accept) & (&ch_idle_next);
            err_q  <= err_q | (|err_set);
        end
    end

    for (genvar c = 0; c < CH_CNT; c++) begin : g_ch
        ch_state_e         state_q, state_d;
        logic [AW-1:0]     addr_q, stride_q;
        logic [LW-1:0]     len_q, idx_q;
        logic [CW-1:0]     out_q, out_d;
        logic [CW-1:0]     wr_ptr_q, rd_ptr_q, count;
        logic [CW:0]       credit_used;
        logic [SW-1:0]     slc_q;
        logic              flush_q;
        logic              req, ack_ok, rv_ok, last_req, empty, pop_slice, pop_word;
        logic [DW-1:0]     mem [DEPTH];
        logic [DW-1:0]     head_word;

        assign count       = wr_ptr_q - rd_ptr_q;
        assign empty       = (count == '0);
        assign credit_used = {1'b0, out_q} + {1'b0, count};
        assign last_req    = (idx_q == len_q - LW'(1));
        assign ack_ok      = req & bus.sram_ack_i[c];
        assign rv_ok       = bus.sram_rvalid_i[c] & (out_q != '0);
        // flush_q hides stragglers from bursts cut short by reset until the next command.
        assign err_set[c]  = bus.sram_rvalid_i[c] & (out_q == '0) & ~flush_q;
        assign out_d       = out_q + CW'(ack_ok) - CW'(rv_ok);
        assign pop_slice   = bus.opnd_rden_i[c] & ~empty;
        assign pop_word    = pop_slice & (slc_q == SW'(NS - 1));

        always_comb begin
            state_d = state_q;
            req     = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept && bus.cmd_ch_mask_i[c] && (bus.cmd_len_i[c*LW +: LW] != '0))
                        state_d = ST_ISSUE;
                end
                ST_ISSUE: begin
                    req = (credit_used < (CW+1)'(DEPTH));
                    if (req && bus.sram_ack_i[c] && last_req)
                        state_d = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (out_d == '0)
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        assign ch_idle_next[c] = (state_d == ST_IDLE);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q  <= ST_IDLE;
                addr_q   <= '0;
                stride_q <= '0;
                len_q    <= '0;
                idx_q    <= '0;
                out_q    <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                slc_q    <= '0;
                flush_q  <= 1'b1;
            end else begin
                state_q <= state_d;
                out_q   <= out_d;
                if (accept) begin
                    addr_q   <= bus.cmd_base_i[c*AW +: AW];
                    stride_q <= bus.cmd_stride_i[c*AW +: AW];
                    len_q    <= bus.cmd_len_i[c*LW +: LW];
                    idx_q    <= '0;
                    flush_q  <= 1'b0;
                end else if (ack_ok) begin
                    addr_q <= addr_q + stride_q;
                    idx_q  <= idx_q + LW'(1);
                end
                if (rv_ok)
                    wr_ptr_q <= wr_ptr_q + CW'(1);
                if (pop_word) begin
                    slc_q    <= '0;
                    rd_ptr_q <= rd_ptr_q + CW'(1);
                end else if (pop_slice) begin
                    slc_q <= slc_q + SW'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rv_ok)
                mem[wr_ptr_q[PW-1:0]] <= bus.sram_rdata_i[c*DW +: DW];
        end

        assign head_word                      = mem[rd_ptr_q[PW-1:0]];
        assign bus.opnd_rdata_o[c*OW +: OW]   = head_word[slc_q*OW +: OW];
        assign bus.opnd_empty_o[c]            = empty;
        assign bus.sram_req_o[c]              = req;
        assign bus.sram_addr_o[c*AW +: AW]    = addr_q;
        assign bus.sram_rid_o[c*IDW +: IDW]   = IDW'(idx_q);
        assign bus.sram_rlast_o[c]            = req & last_req;
        assign bus.dbg_state[c*2 +: 2]        = state_q;

`ifdef VPU_SRC_STREAM_PERF_EN
        logic [31:0] stall_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                stall_q <= '0;
            else if (accept)
                stall_q <= '0;
            else if ((state_q == ST_ISSUE) && !req && (stall_q != '1))
                stall_q <= stall_q + 32'd1;
        end
        assign perf_stall_cnt_o[c*32 +: 32] = stall_q;
`endif
    end
endmodule

// File: tb/tb_vpu_src_stream_port.sv
// Directed bench for vpu_src_stream_port: burst table, credit limit, no-work command, error and reset cases.
module tb_vpu_src_stream_port;
    localparam int CH_CNT = 2, AW = 16, LW = 8, IDW = 4, DW = 512, OW = 256, DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vpu_src_stream_port_if #(.CH_CNT(CH_CNT), .AW(AW), .LW(LW), .IDW(IDW), .DW(DW), .OW(OW)) bus ();

`ifdef VPU_SRC_STREAM_PERF_EN
    logic [CH_CNT*32-1:0] perf_cnt;
`endif

    vpu_src_stream_port #(.CH_CNT(CH_CNT), .AW(AW), .LW(LW), .IDW(IDW), .DW(DW), .OW(OW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef VPU_SRC_STREAM_PERF_EN
        ,
        .perf_stall_cnt_o (perf_cnt)
`endif
    );

    typedef struct packed {
        logic [0:0]       ch;
        logic [15:0]      base;
        logic [15:0]      stride;
        logic [7:0]       len;
        logic [3:0][15:0] addr;
    } vec_t;

    vec_t            tbl [4];
    vec_t            v;
    logic [OW-1:0]   exp_q[$];
    logic [AW-1:0]   exp_addr_q[$];
    int              n_cmp = 0, n_bad = 0;
    int              ack_cnt = 0, done_cnt = 0;
    logic [OW-1:0]   saved;

    function automatic logic [OW-1:0] pat_lo(input logic [AW-1:0] a);
        return {16{a}};
    endfunction

    function automatic logic [OW-1:0] pat_hi(input logic [AW-1:0] a);
        return {16{a ^ 16'h5A5A}};
    endfunction

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, bus.cmd_ready_o, 1);
        chk({tag, "_busy"},  bus.busy_o, 0);
        chk({tag, "_done"},  bus.done_o, 0);
        chk({tag, "_err"},   bus.err_o, 0);
        chk({tag, "_req"},   bus.sram_req_o, 0);
        chk({tag, "_rlast"}, bus.sram_rlast_o, 0);
        chk({tag, "_addr"},  bus.sram_addr_o, 0);
        chk({tag, "_rid"},   bus.sram_rid_o, 0);
        chk({tag, "_empty"}, bus.opnd_empty_o, 2'b11);
    endtask

    task automatic clear_inputs();
        bus.sram_ack_i    = '0;
        bus.sram_rvalid_i = '0;
        bus.opnd_rden_i   = '0;
    endtask

    task automatic send_cmd(input logic [1:0] mask, input logic [31:0] base, input logic [31:0] stride,
                            input logic [15:0] len);
        chk("cmd_ready_idle", bus.cmd_ready_o, 1);
        bus.cmd_valid_i   = 1'b1;
        bus.cmd_ch_mask_i = mask;
        bus.cmd_base_i    = base;
        bus.cmd_stride_i  = stride;
        bus.cmd_len_i     = len;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        ack_cnt  = 0;
        done_cnt = 0;
    endtask

    // SRAM + operand consumer: samples at negedge, drives the inputs for the next posedge.
    task automatic serve(input int ch, input int len, input int max_cyc, input bit rden_on,
                         input bit stop_done, input bit ack_gap);
        logic [DW-1:0] pend[$];
        logic [AW-1:0] da;
        for (int c = 0; c < max_cyc; c++) begin
            clear_inputs();
            if (bus.done_o) begin
                done_cnt++;
                if (stop_done) break;
            end
            if (pend.size() > 0) begin
                bus.sram_rvalid_i[ch] = 1'b1;
                bus.sram_rdata_i[ch*DW +: DW] = pend.pop_front();
            end
            if (bus.sram_req_o[ch]) begin
                da = bus.sram_addr_o[ch*AW +: AW];
                if (exp_addr_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL extra_req: got request at %h expected none", da);
                end else begin
                    chk("addr",  da, exp_addr_q[0]);
                    chk("rid",   bus.sram_rid_o[ch*IDW +: IDW], ack_cnt % 16);
                    chk("rlast", bus.sram_rlast_o[ch], (ack_cnt == len - 1));
                    if (!(ack_gap && (c % 3 == 1))) begin
                        exp_q.push_back(pat_lo(exp_addr_q[0]));
                        exp_q.push_back(pat_hi(exp_addr_q[0]));
                        void'(exp_addr_q.pop_front());
                        bus.sram_ack_i[ch] = 1'b1;
                        pend.push_back({pat_hi(da), pat_lo(da)});
                        ack_cnt++;
                    end
                end
            end
            chk("other_req", bus.sram_req_o[1-ch], 0);
            if (rden_on && !bus.opnd_empty_o[ch]) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL extra_data: got %h expected empty queue", bus.opnd_rdata_o[ch*OW +: OW]);
                end else begin
                    chk("rdata", bus.opnd_rdata_o[ch*OW +: OW], exp_q.pop_front());
                end
                bus.opnd_rden_i[ch] = 1'b1;
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] b, s;
        logic [15:0] l;

        tbl[0] = '{ch:1'b0, base:16'h0010, stride:16'h0002, len:8'd4,
                   addr:{16'h0016, 16'h0014, 16'h0012, 16'h0010}};
        tbl[1] = '{ch:1'b0, base:16'hFFFE, stride:16'h0001, len:8'd3,
                   addr:{16'h0000, 16'h0000, 16'hFFFF, 16'hFFFE}};
        tbl[2] = '{ch:1'b1, base:16'h0100, stride:16'h0040, len:8'd2,
                   addr:{16'h0000, 16'h0000, 16'h0140, 16'h0100}};
        tbl[3] = '{ch:1'b1, base:16'hFFF0, stride:16'h0008, len:8'd4,
                   addr:{16'h0008, 16'h0000, 16'hFFF8, 16'hFFF0}};

        bus.cmd_valid_i = 1'b0; bus.cmd_ch_mask_i = '0; bus.cmd_base_i = '0;
        bus.cmd_stride_i = '0; bus.cmd_len_i = '0; bus.sram_rdata_i = '0;
        clear_inputs();

        // Clock/reset
        repeat (2) @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset("post_rst");

        // Burst table; the unmasked channel carries len=5 and must stay silent
        for (int t = 0; t < 4; t++) begin
            v = tbl[t];
            for (int k = 0; k < v.len; k++) exp_addr_q.push_back(v.addr[k]);
            b = '0; s = '0; l = {8'd5, 8'd5};
            b[v.ch*16 +: 16] = v.base;
            s[v.ch*16 +: 16] = v.stride;
            l[v.ch*8 +: 8]   = v.len;
            send_cmd(2'b01 << v.ch, b, s, l);
            chk("busy_rise", bus.busy_o, 1);
            chk("ready_drop", bus.cmd_ready_o, 0);
            serve(v.ch, v.len, 80, 1'b0, 1'b1, (t >= 2));
            chk("done_seen", done_cnt, 1);
            chk("ack_count", ack_cnt, v.len);
            chk("busy_fall", bus.busy_o, 0);
            chk("ready_rise", bus.cmd_ready_o, 1);
            @(negedge clk);
            chk("done_pulse_end", bus.done_o, 0);
            serve(v.ch, v.len, 2 * v.len + 4, 1'b1, 1'b0, 1'b0);
            chk("exp_q_drained", exp_q.size(), 0);
            chk("queue_empty", bus.opnd_empty_o[v.ch], 1);
            if (t == 0) begin
                saved = bus.opnd_rdata_o[OW-1:0];
                bus.opnd_rden_i[0] = 1'b1;
                @(negedge clk);
                bus.opnd_rden_i[0] = 1'b0;
                chk("rden_empty_rdata", bus.opnd_rdata_o[OW-1:0], saved);
                chk("rden_empty_flag", bus.opnd_empty_o[0], 1);
            end
        end

        // No work at all: done the cycle after accept
        send_cmd(2'b11, 32'h0, 32'h0, 16'h0);
        chk("nowork_done", bus.done_o, 1);
        chk("nowork_busy", bus.busy_o, 0);
        chk("nowork_ready", bus.cmd_ready_o, 1);
        chk("nowork_req", bus.sram_req_o, 0);
        @(negedge clk);
        chk("nowork_done_end", bus.done_o, 0);

        // Credit limit: len=12 with no pops stalls after DEPTH acks
        for (int i = 0; i < 12; i++) exp_addr_q.push_back(16'h0200 + 16'(i * 4));
        send_cmd(2'b01, 32'h0000_0200, 32'h0000_0004, 16'h000C);
        serve(0, 12, 40, 1'b0, 1'b0, 1'b0);
        chk("credit_acks", ack_cnt, DEPTH);
        chk("credit_req_low", bus.sram_req_o[0], 0);
        bus.sram_ack_i[0] = 1'b1;
        repeat (3) @(negedge clk);
        bus.sram_ack_i[0] = 1'b0;
        chk("credit_full", bus.opnd_empty_o[0], 0);
        for (int i = 0; i < 2; i++) begin
            chk("credit_pop", bus.opnd_rdata_o[OW-1:0], exp_q.pop_front());
            bus.opnd_rden_i[0] = 1'b1;
            @(negedge clk);
        end
        bus.opnd_rden_i[0] = 1'b0;
        chk("credit_req_again", bus.sram_req_o[0], 1);
        serve(0, 12, 200, 1'b1, 1'b1, 1'b0);
        chk("credit_total_acks", ack_cnt, 12);
        chk("credit_done", done_cnt, 1);
        serve(0, 12, 40, 1'b1, 1'b0, 1'b0);
        chk("credit_drained", exp_q.size(), 0);

        // Stray rvalid with nothing outstanding
        bus.sram_rvalid_i[1] = 1'b1;
        bus.sram_rdata_i[DW +: DW] = {DW{1'b1}};
        @(negedge clk);
        bus.sram_rvalid_i[1] = 1'b0;
        chk("err_set", bus.err_o, 1);
        chk("err_queue", bus.opnd_empty_o[1], 1);
        @(negedge clk);
        chk("err_sticky", bus.err_o, 1);

        // Reset mid-burst, then a straggling response
        for (int i = 0; i < 12; i++) exp_addr_q.push_back(16'h0300 + 16'(i));
        send_cmd(2'b01, 32'h0000_0300, 32'h0000_0001, 16'h000C);
        serve(0, 12, 4, 1'b0, 1'b0, 1'b0);
        chk("mid_busy", bus.busy_o, 1);
        rst_n = 1'b0;
        #1;
        chk_reset("mid_rst");
        exp_q.delete();
        exp_addr_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus.sram_rvalid_i[0] = 1'b1;
        @(negedge clk);
        bus.sram_rvalid_i[0] = 1'b0;
        chk("straggler_err", bus.err_o, 0);
        chk("straggler_empty", bus.opnd_empty_o[0], 1);
        chk("straggler_req", bus.sram_req_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
